// File: rtl/reg_xfer_sequencer_pkg.sv
// reg_xfer_sequencer_pkg
// Shared definitions for the register-transfer sequencer and the control
// unit that drives the same register file: command opcodes, FSM state
// encodings and the bit positions of the fields inside rf_rslct.
package reg_xfer_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_COPY = 2'd1,
    OP_PCLD = 2'd2,
    OP_READ = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XFER = 3'd1,
    ST_PCLD = 3'd2,
    ST_READ = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam int RSLCT_W      = 20;
  localparam int RSLCT_RN_LSB = 16;
  localparam int RSLCT_RD_LSB = 12;
  localparam int RSLCT_RS_LSB = 8;
  localparam int RSLCT_RM_LSB = 0;

  // Build the register-select bus. The sequencer never uses the Rs or Rm
  // read ports, so those fields (and the reserved nibble) are held at 0.
  function automatic logic [RSLCT_W-1:0] packRslct(input logic [3:0] rnSel,
                                                   input logic [3:0] rdSel);
    logic [RSLCT_W-1:0] v;
    v = '0;
    v[RSLCT_RN_LSB +: 4] = rnSel;
    v[RSLCT_RD_LSB +: 4] = rdSel;
    v[RSLCT_RS_LSB +: 4] = 4'd0;
    v[RSLCT_RM_LSB +: 4] = 4'd0;
    return v;
  endfunction

endpackage

// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer
// Executes block commands against a 16-entry register file:
//   FILL  write imm into cnt+1 consecutive registers starting at rd
//   COPY  copy cnt+1 registers from rn.. to rd.. in ascending order
//   PCLD  load imm into the PC
//   READ  return the value of register rn
// Each command finishes with a held response (rsp_valid/rsp_ready).
// Ports:
//   Clk, RESET            clock, synchronous active-low reset
//   cmd_*                 command handshake and fields
//   rsp_valid/ready/data  response handshake; data is 0 except for READ
//   rf_in, rf_pcin        write data to the register file / PC
//   rf_rslct              {Rn, Rd, Rs, 0, Rm} register selects
//   rf_load, rf_loadpc    register / PC write enables
//   rf_ir_cu              address source select, tied to 1
//   rf_rn                 combinational Rn read data from the register file
module reg_xfer_sequencer
  import reg_xfer_sequencer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         RESET,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [3:0]   cmd_rd,
  input  logic [3:0]   cmd_rn,
  input  logic [3:0]   cmd_cnt,
  input  logic [W-1:0] cmd_imm,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] rf_in,
  output logic [W-1:0] rf_pcin,
  output logic [19:0]  rf_rslct,
  output logic         rf_load,
  output logic         rf_loadpc,
  output logic         rf_ir_cu,
  input  logic [W-1:0] rf_rn
);

  state_e       r_state;
  logic [3:0]   r_idx;
  logic [3:0]   r_rd;
  logic [3:0]   r_rn;
  logic [3:0]   r_cnt;
  logic         r_copyPass;
  logic         r_cmdReady;
  logic         r_rspValid;
  logic [W-1:0] r_rspData;
  logic [W-1:0] r_rfIn;
  logic [W-1:0] r_rfPcin;
  logic [3:0]   r_rnSel;
  logic [3:0]   r_rdSel;
  logic         r_load;
  logic         r_loadPc;
  op_e          w_cmdOp;

  assign w_cmdOp = op_e'(cmd_op);

  // Sequencer FSM. Outputs are registered one step ahead: the edge that
  // accepts a command already sets up the selects/enables for the first
  // element, so the first write lands on the very next edge.
  always_ff @(posedge Clk) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_rd       <= '0;
      r_rn       <= '0;
      r_cnt      <= '0;
      r_copyPass <= 1'b0;
      r_cmdReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rfIn     <= '0;
      r_rfPcin   <= '0;
      r_rnSel    <= '0;
      r_rdSel    <= '0;
      r_load     <= 1'b0;
      r_loadPc   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmdReady) begin
            r_cmdReady <= 1'b0;
            r_rd       <= cmd_rd;
            r_rn       <= cmd_rn;
            r_cnt      <= cmd_cnt;
            r_idx      <= '0;
            unique case (w_cmdOp)
              OP_FILL, OP_COPY: begin
                r_state    <= ST_XFER;
                r_rdSel    <= cmd_rd;
                r_rnSel    <= cmd_rn;
                r_load     <= 1'b1;
                r_copyPass <= (w_cmdOp == OP_COPY);
                r_rfIn     <= (w_cmdOp == OP_FILL) ? cmd_imm : '0;
              end
              OP_PCLD: begin
                r_state  <= ST_PCLD;
                r_rfPcin <= cmd_imm;
                r_loadPc <= 1'b1;
              end
              OP_READ: begin
                r_state <= ST_READ;
                r_rnSel <= cmd_rn;
              end
            endcase
          end else begin
            r_cmdReady <= 1'b1;
          end
        end

        ST_XFER: begin
          if (r_idx == r_cnt) begin
            r_state    <= ST_RESP;
            r_rspValid <= 1'b1;
            r_rspData  <= '0;
            r_idx      <= '0;
            r_load     <= 1'b0;
            r_copyPass <= 1'b0;
            r_rfIn     <= '0;
            r_rdSel    <= '0;
            r_rnSel    <= '0;
          end else begin
            // 4-bit sums wrap naturally, giving the mod-16 register walk.
            r_idx   <= r_idx + 4'd1;
            r_rdSel <= r_rd + r_idx + 4'd1;
            r_rnSel <= r_rn + r_idx + 4'd1;
          end
        end

        ST_PCLD: begin
          r_state    <= ST_RESP;
          r_rspValid <= 1'b1;
          r_rspData  <= '0;
          r_loadPc   <= 1'b0;
          r_rfPcin   <= '0;
        end

        ST_READ: begin
          r_state    <= ST_RESP;
          r_rspValid <= 1'b1;
          r_rspData  <= rf_rn;
          r_rnSel    <= '0;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_state    <= ST_IDLE;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_cmdReady <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write enables are masked by RESET so that asserting reset in the middle
  // of a transfer suppresses the write that would otherwise land on the
  // reset edge; registers written before that edge keep their values.
  assign rf_load   = r_load & RESET;
  assign rf_loadpc = r_loadPc & RESET;

  // COPY data is a straight pass-through of the Rn read port so the value
  // read and the value written belong to the same element.
  assign rf_in     = r_copyPass ? rf_rn : r_rfIn;
  assign rf_pcin   = r_rfPcin;
  assign rf_rslct  = packRslct(r_rnSel, r_rdSel);
  assign rf_ir_cu  = 1'b1;
  assign cmd_ready = r_cmdReady;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// tb_reg_xfer_sequencer
// Drives reg_xfer_sequencer against a behavioural 16-entry register file
// plus PC, using a table of commands with hand-computed results and a few
// hand-written sequences for handshake stalls, throughput and reset abort.
`timescale 1ns/1ps
module tb_reg_xfer_sequencer;

  localparam int W = 32;
  localparam logic [1:0] OPC_FILL = 2'd0;
  localparam logic [1:0] OPC_COPY = 2'd1;
  localparam logic [1:0] OPC_PCLD = 2'd2;
  localparam logic [1:0] OPC_READ = 2'd3;
  localparam int NVEC = 11;

  logic         Clk = 1'b0;
  logic         RESET;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_rd;
  logic [3:0]   cmd_rn;
  logic [3:0]   cmd_cnt;
  logic [W-1:0] cmd_imm;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [W-1:0] rf_in;
  logic [W-1:0] rf_pcin;
  logic [19:0]  rf_rslct;
  logic         rf_load;
  logic         rf_loadpc;
  logic         rf_ir_cu;
  logic [W-1:0] rf_rn;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  reg_xfer_sequencer #(.W(W)) dut (
    .Clk(Clk), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_cnt(cmd_cnt), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rf_in(rf_in), .rf_pcin(rf_pcin), .rf_rslct(rf_rslct),
    .rf_load(rf_load), .rf_loadpc(rf_loadpc), .rf_ir_cu(rf_ir_cu),
    .rf_rn(rf_rn)
  );

  // Behavioural register file: combinational Rn read, edge-triggered writes.
  // doPreset reloads a known pattern (Ri = 0xA0+i, R1 = 7).
  logic [W-1:0] regs [16];
  logic [W-1:0] pcReg;
  logic         doPreset = 1'b0;

  assign rf_rn = regs[rf_rslct[19:16]];

  always @(posedge Clk) begin
    if (doPreset) begin
      for (int i = 0; i < 16; i++) regs[i] <= W'(32'hA0 + i);
      regs[1] <= W'(7);
    end else if (rf_load) begin
      regs[rf_rslct[15:12]] <= rf_in;
    end
    if (rf_loadpc) pcReg <= rf_pcin;
  end

  // Activity monitors: write pulses, illegal double enables, accept times.
  int loadCount = 0;
  int bothHigh = 0;
  int cyc = 0;
  int acceptCount = 0;
  int lastAcceptCyc = 0;
  int prevAcceptCyc = 0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (rf_load) loadCount <= loadCount + 1;
    if (rf_load && rf_loadpc) bothHigh <= bothHigh + 1;
    if (cmd_valid && cmd_ready) begin
      acceptCount   <= acceptCount + 1;
      prevAcceptCyc <= lastAcceptCyc;
      lastAcceptCyc <= cyc;
    end
  end

  typedef struct {
    logic [1:0]   op;
    logic [3:0]   rd;
    logic [3:0]   rn;
    logic [3:0]   cnt;
    logic [W-1:0] imm;
    logic [W-1:0] expRsp;
    int           expLat;
    int           expLoads;
    int           chkReg;
    logic [W-1:0] chkVal;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] modelVal(input int idx);
    if (idx == 16) return pcReg;
    return regs[idx[3:0]];
  endfunction

  // Offer a command and return #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] rd,
                               input logic [3:0] rn, input logic [3:0] cnt,
                               input logic [W-1:0] imm);
    int n;
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_cnt = cnt; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic runVec(input int k, input vec_t v);
    int base;
    int lat;
    base = loadCount;
    applyStimulus(v.op, v.rd, v.rn, v.cnt, v.imm);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput($sformatf("vec%0d_latency", k), W'(lat), W'(v.expLat));
    checkOutput($sformatf("vec%0d_rsp_data", k), rsp_data, v.expRsp);
    checkOutput($sformatf("vec%0d_load_pulses", k), W'(loadCount - base), W'(v.expLoads));
    checkOutput($sformatf("vec%0d_reg%0d", k, v.chkReg), modelVal(v.chkReg), v.chkVal);
    tick();
  endtask

  // Hold cmd_valid with a repeating command and measure edges between the
  // first two acceptances.
  task automatic measureGap(input logic [1:0] op, input logic [3:0] rd,
                            input logic [3:0] cnt, input logic [W-1:0] imm,
                            output int gap);
    int start;
    int n;
    cmd_op = op; cmd_rd = rd; cmd_rn = 4'd0; cmd_cnt = cnt; cmd_imm = imm;
    cmd_valid = 1'b1;
    start = acceptCount;
    n = 0;
    while (acceptCount < start + 2 && n < 60) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    gap = (acceptCount >= start + 2) ? (lastAcceptCyc - prevAcceptCyc) : -1;
    n = 0;
    while (!cmd_ready && n < 30) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int gap;

    vecs[0]  = '{OPC_COPY, 4'd4,  4'd1, 4'd0, 32'h0,   32'h0,  1, 1, 4,  32'h7};
    vecs[1]  = '{OPC_READ, 4'd0,  4'd4, 4'd0, 32'h0,   32'h7,  1, 0, 4,  32'h7};
    vecs[2]  = '{OPC_FILL, 4'd15, 4'd0, 4'd1, 32'h9,   32'h0,  2, 2, 15, 32'h9};
    vecs[3]  = '{OPC_READ, 4'd0,  4'd0, 4'd0, 32'h0,   32'h9,  1, 0, 0,  32'h9};
    vecs[4]  = '{OPC_READ, 4'd0,  4'd1, 4'd0, 32'h0,   32'h7,  1, 0, 1,  32'h7};
    vecs[5]  = '{OPC_COPY, 4'd8,  4'd7, 4'd2, 32'h0,   32'h0,  3, 3, 10, 32'hA7};
    vecs[6]  = '{OPC_READ, 4'd0,  4'd9, 4'd0, 32'h0,   32'hA7, 1, 0, 9,  32'hA7};
    vecs[7]  = '{OPC_PCLD, 4'd0,  4'd0, 4'd0, 32'h100, 32'h0,  1, 0, 16, 32'h100};
    vecs[8]  = '{OPC_COPY, 4'd14, 4'd2, 4'd3, 32'h0,   32'h0,  4, 4, 1,  32'hA5};
    vecs[9]  = '{OPC_READ, 4'd0,  4'd0, 4'd0, 32'h0,   32'h7,  1, 0, 0,  32'h7};
    vecs[10] = '{OPC_READ, 4'd0,  4'd15, 4'd0, 32'h0,  32'hA3, 1, 0, 15, 32'hA3};

    RESET = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_rd = 4'd0;
    cmd_rn = 4'd0; cmd_cnt = 4'd0; cmd_imm = '0; rsp_ready = 1'b1;
    doPreset = 1'b1;
    tick();
    tick();
    doPreset = 1'b0;
    checkOutput("reset_cmd_ready", W'(cmd_ready), W'(0));
    checkOutput("reset_rsp_valid", W'(rsp_valid), W'(0));
    checkOutput("reset_rsp_data", rsp_data, '0);
    checkOutput("reset_rf_load", W'(rf_load), W'(0));
    checkOutput("reset_rf_loadpc", W'(rf_loadpc), W'(0));
    checkOutput("reset_rf_in", rf_in, '0);
    checkOutput("reset_rf_pcin", rf_pcin, '0);
    checkOutput("reset_rf_rslct", W'(rf_rslct), W'(0));
    checkOutput("reset_rf_ir_cu", W'(rf_ir_cu), W'(1));
    RESET = 1'b1;
    tick();
    checkOutput("release_cmd_ready", W'(cmd_ready), W'(1));

    // FILL rd=0 cnt=2 imm=5: three back-to-back writes, then response.
    applyStimulus(OPC_FILL, 4'd0, 4'd0, 4'd2, 32'd5);
    checkOutput("fill_w0_load", W'(rf_load), W'(1));
    checkOutput("fill_w0_rd", W'(rf_rslct[15:12]), W'(0));
    checkOutput("fill_w0_data", rf_in, 32'd5);
    checkOutput("fill_w0_cmd_ready", W'(cmd_ready), W'(0));
    tick();
    checkOutput("fill_w1_rd", W'(rf_rslct[15:12]), W'(1));
    checkOutput("fill_w1_load", W'(rf_load), W'(1));
    checkOutput("fill_r0", regs[0], 32'd5);
    tick();
    checkOutput("fill_w2_rd", W'(rf_rslct[15:12]), W'(2));
    checkOutput("fill_r1", regs[1], 32'd5);
    tick();
    checkOutput("fill_r2", regs[2], 32'd5);
    checkOutput("fill_done_load", W'(rf_load), W'(0));
    checkOutput("fill_rsp_valid", W'(rsp_valid), W'(1));
    checkOutput("fill_rsp_data", rsp_data, '0);
    checkOutput("fill_resp_rd", W'(rf_rslct[15:12]), W'(0));
    tick();

    doPreset = 1'b1;
    tick();
    doPreset = 1'b0;

    for (int k = 0; k < NVEC; k++) runVec(k, vecs[k]);

    measureGap(OPC_PCLD, 4'd0, 4'd0, 32'h200, gap);
    checkOutput("throughput_pcld", W'(gap), W'(3));
    measureGap(OPC_FILL, 4'd5, 4'd1, 32'h55, gap);
    checkOutput("throughput_fill_cnt1", W'(gap), W'(4));

    // PCLD with the response stalled for four cycles.
    rsp_ready = 1'b0;
    base = loadCount;
    applyStimulus(OPC_PCLD, 4'd0, 4'd0, 4'd0, 32'h100);
    checkOutput("pcld_loadpc", W'(rf_loadpc), W'(1));
    checkOutput("pcld_pcin", rf_pcin, 32'h100);
    checkOutput("pcld_load", W'(rf_load), W'(0));
    tick();
    checkOutput("pcld_pc", pcReg, 32'h100);
    checkOutput("pcld_rsp_valid", W'(rsp_valid), W'(1));
    checkOutput("pcld_loadpc_off", W'(rf_loadpc), W'(0));
    checkOutput("pcld_pcin_off", rf_pcin, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("stall%0d_rsp_valid", i), W'(rsp_valid), W'(1));
      checkOutput($sformatf("stall%0d_cmd_ready", i), W'(cmd_ready), W'(0));
      checkOutput($sformatf("stall%0d_rsp_data", i), rsp_data, '0);
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("stall_release_rsp_valid", W'(rsp_valid), W'(0));
    checkOutput("stall_release_cmd_ready", W'(cmd_ready), W'(1));
    checkOutput("pcld_no_load", W'(loadCount - base), W'(0));

    // FILL rd=0 cnt=15 imm=3 aborted by reset during the 4th write cycle.
    doPreset = 1'b1;
    tick();
    doPreset = 1'b0;
    base = loadCount;
    applyStimulus(OPC_FILL, 4'd0, 4'd0, 4'd15, 32'd3);
    tick();
    tick();
    tick();
    checkOutput("abort_w3_rd", W'(rf_rslct[15:12]), W'(3));
    checkOutput("abort_w3_load_before", W'(rf_load), W'(1));
    RESET = 1'b0;
    #1;
    checkOutput("abort_load_in_reset", W'(rf_load), W'(0));
    tick();
    checkOutput("abort_load_after_edge", W'(rf_load), W'(0));
    checkOutput("abort_cmd_ready", W'(cmd_ready), W'(0));
    checkOutput("abort_rslct", W'(rf_rslct), W'(0));
    checkOutput("abort_rf_in", rf_in, '0);
    checkOutput("abort_rsp_valid", W'(rsp_valid), W'(0));
    RESET = 1'b1;
    tick();
    checkOutput("abort_release_cmd_ready", W'(cmd_ready), W'(1));
    checkOutput("abort_release_load", W'(rf_load), W'(0));
    checkOutput("abort_load_pulses", W'(loadCount - base), W'(3));
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("abort_r%0d", i), regs[i],
                  (i < 3) ? W'(3) : W'(32'hA0 + i));
    end

    checkOutput("load_loadpc_exclusive", W'(bothHigh), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
